// File: rtl/mem_stage_pkg.sv
// Shared proc definitions: datapath widths, opcode encoding and opcode-class helpers.
package mem_stage_pkg;
  localparam int ARCH_BITS = 32;
  localparam int REG_BITS  = 5;
  localparam int OPCODE_W  = 7;

  localparam logic [OPCODE_W-1:0] OPCODE_ADD  = 7'h01;
  localparam logic [OPCODE_W-1:0] OPCODE_SUB  = 7'h02;
  localparam logic [OPCODE_W-1:0] OPCODE_LDB  = 7'h03;
  localparam logic [OPCODE_W-1:0] OPCODE_LDW  = 7'h04;
  localparam logic [OPCODE_W-1:0] OPCODE_STB  = 7'h05;
  localparam logic [OPCODE_W-1:0] OPCODE_STW  = 7'h06;
  localparam logic [OPCODE_W-1:0] OPCODE_BEQ  = 7'h07;
  localparam logic [OPCODE_W-1:0] OPCODE_BZ   = 7'h08;
  localparam logic [OPCODE_W-1:0] OPCODE_JUMP = 7'h09;

  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_LDB) || (op == OPCODE_LDW) ||
           (op == OPCODE_STB) || (op == OPCODE_STW);
  endfunction

  function automatic logic is_load_op(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_LDB) || (op == OPCODE_LDW);
  endfunction

  function automatic logic is_byte_op(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_LDB) || (op == OPCODE_STB);
  endfunction

  // Unknown opcodes still retire, but never write the register file.
  function automatic logic writes_reg(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_ADD) || (op == OPCODE_SUB) || is_load_op(op);
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte lane and sign-extends it, or passes the word.
module load_align #(
  parameter int ARCH_BITS = mem_stage_pkg::ARCH_BITS
) (
  input  logic [ARCH_BITS-1:0] rdata,
  input  logic [1:0]           lane,
  input  logic                 byte_sel,
  output logic [ARCH_BITS-1:0] data
);
  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = rdata[{lane, 3'b000} +: 8];
    data      = byte_sel ? {{(ARCH_BITS-8){lane_byte[7]}}, lane_byte} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack port, stalls upstream
// while an access is in flight, and passes other instructions to writeback in one cycle.
module mem_stage #(
  parameter int ARCH_BITS = mem_stage_pkg::ARCH_BITS,
  parameter int REG_BITS  = mem_stage_pkg::REG_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [6:0]           ex_opcode,
  input  logic [ARCH_BITS-1:0] ex_alu_res,
  input  logic [ARCH_BITS-1:0] ex_store_data,
  input  logic [REG_BITS-1:0]  ex_dst_reg,
  output logic                 ex_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ARCH_BITS-1:0] mem_addr,
  output logic [ARCH_BITS-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic [ARCH_BITS-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [REG_BITS-1:0]  wb_dst_reg,
  output logic [ARCH_BITS-1:0] wb_data
);
  import mem_stage_pkg::*;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_ACK = 2'd1;
  localparam logic [1:0] S_RESP     = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [6:0]           op_q, op_d;
  logic [ARCH_BITS-1:0] alu_q, alu_d;
  logic [REG_BITS-1:0]  dst_q, dst_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ARCH_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [ARCH_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic                 wb_valid_q, wb_valid_d;
  logic                 wb_we_q, wb_we_d;
  logic [REG_BITS-1:0]  wb_dst_q, wb_dst_d;
  logic [ARCH_BITS-1:0] wb_data_q, wb_data_d;
  logic [ARCH_BITS-1:0] ld_data;

  load_align #(.ARCH_BITS(ARCH_BITS)) u_load_align (
    .rdata    (mem_rdata),
    .lane     (alu_q[1:0]),
    .byte_sel (op_q == OPCODE_LDB),
    .data     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    alu_d       = alu_q;
    dst_d       = dst_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = wb_we_q;
    wb_dst_d    = wb_dst_q;
    wb_data_d   = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (is_mem_op(ex_opcode)) begin
            op_d      = ex_opcode;
            alu_d     = ex_alu_res;
            dst_d     = ex_dst_reg;
            mem_req_d = 1'b1;
            mem_we_d  = !is_load_op(ex_opcode);
            // Byte stores replicate the byte on every lane; mem_be selects the live one.
            if (is_byte_op(ex_opcode)) begin
              mem_addr_d  = ex_alu_res;
              mem_be_d    = 4'b0001 << ex_alu_res[1:0];
              mem_wdata_d = {(ARCH_BITS/8){ex_store_data[7:0]}};
            end else begin
              mem_addr_d  = {ex_alu_res[ARCH_BITS-1:2], 2'b00};
              mem_be_d    = 4'hF;
              mem_wdata_d = ex_store_data;
            end
            state_d = S_WAIT_ACK;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = writes_reg(ex_opcode);
            wb_dst_d   = ex_dst_reg;
            wb_data_d  = ex_alu_res;
          end
        end
      end
      S_WAIT_ACK: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = writes_reg(op_q);
          wb_dst_d   = dst_q;
          wb_data_d  = is_load_op(op_q) ? ld_data : alu_q;
          state_d    = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      alu_q       <= '0;
      dst_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_dst_q    <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      alu_q       <= alu_d;
      dst_q       <= dst_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_dst_q    <= wb_dst_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign ex_stall   = (state_q != S_IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_dst_reg = wb_dst_q;
  assign wb_data    = wb_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected writebacks and memory
// requests; a memory responder and a writeback monitor check them as the DUT presents them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] data;
    bit          is_mem;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
    logic [31:0] rdata;
  } mem_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [31:0] ex_alu_res, ex_store_data;
  logic [4:0]  ex_dst_reg;
  logic        ex_stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_dst_reg;
  logic [31:0] wb_data;

  int       checks = 0;
  int       passes = 0;
  int       cyc = 0;
  int       last_ack_cyc = -10;
  bit       stray_ack = 1'b0;
  wb_exp_t  wbq[$];
  mem_exp_t mq[$];

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data), .ex_dst_reg(ex_dst_reg),
    .ex_stall(ex_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dst_reg(wb_dst_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Presents one instruction, holds it while stalled, and records what it should produce.
  task automatic issue(input logic [6:0] op, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] dst, input logic wb_we_e, input logic [31:0] wb_data_e,
                       input bit is_mem, input logic mwe, input logic [31:0] maddr,
                       input logic [31:0] mwdata, input logic [3:0] mbe, input int mdelay,
                       input logic [31:0] mrdata);
    int n;
    wb_exp_t  w;
    mem_exp_t m;
    n = 0;
    ex_valid = 1'b1; ex_opcode = op; ex_alu_res = alu; ex_store_data = sd; ex_dst_reg = dst;
    while (ex_stall && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_stall_bound", {31'b0, ex_stall}, 32'd0);
    if (ex_stall) begin
      ex_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    w.we = wb_we_e; w.dst = dst; w.data = wb_data_e; w.is_mem = is_mem; w.cyc = cyc;
    wbq.push_back(w);
    if (is_mem) begin
      m.we = mwe; m.addr = maddr; m.wdata = mwdata; m.be = mbe; m.delay = mdelay; m.rdata = mrdata;
      mq.push_back(m);
    end
  endtask

  task automatic pass_op(input logic [6:0] op, input logic [31:0] alu, input logic [4:0] dst,
                         input logic we_e);
    issue(op, alu, 32'h0, dst, we_e, alu, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
  endtask

  // Memory responder: checks each request on its first cycle, acks after the programmed delay.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0BAD0BAD;
    forever begin
      @(negedge clk);
      mem_ack = stray_ack;
      mem_rdata = 32'h0BAD0BAD;
      if (mem_req === 1'b1 && rst === 1'b0) begin
        chk("req_stall", {31'b0, ex_stall}, 32'd1);
        if (mq.size() == 0) begin
          chk("mem_unexpected_req", {31'b0, mem_req}, 32'd0);
        end else begin
          if (cnt == 0) begin
            chk("mem_addr", mem_addr, mq[0].addr);
            chk("mem_be", {28'b0, mem_be}, {28'b0, mq[0].be});
            chk("mem_we", {31'b0, mem_we}, {31'b0, mq[0].we});
            if (mq[0].we) chk("mem_wdata", mem_wdata, mq[0].wdata);
          end
          if (cnt == mq[0].delay) begin
            mem_ack = 1'b1;
            mem_rdata = mq[0].rdata;
            last_ack_cyc = cyc;
            void'(mq.pop_front());
            cnt = 0;
          end else cnt++;
        end
      end else cnt = 0;
    end
  end

  // Writeback monitor: every retirement must match the oldest expected one, at the right cycle.
  initial forever begin
    wb_exp_t e;
    @(negedge clk);
    if (wb_valid === 1'b1 && rst === 1'b0) begin
      if (wbq.size() == 0) begin
        chk("wb_unexpected", {31'b0, wb_valid}, 32'd0);
      end else begin
        e = wbq.pop_front();
        chk("wb_dst_reg", {27'b0, wb_dst_reg}, {27'b0, e.dst});
        chk("wb_we", {31'b0, wb_we}, {31'b0, e.we});
        chk("wb_data", wb_data, e.data);
        if (e.is_mem) begin
          chk("wb_mem_latency", cyc, last_ack_cyc + 1);
          chk("resp_stall", {31'b0, ex_stall}, 32'd1);
        end else begin
          chk("wb_pass_latency", cyc, e.cyc);
          chk("pass_stall", {31'b0, ex_stall}, 32'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_alu_res = '0; ex_store_data = '0; ex_dst_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_we", {31'b0, wb_we}, 32'd0);
    chk("rst_wb_dst", {27'b0, wb_dst_reg}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_ex_stall", {31'b0, ex_stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pass-through ALU op, then idle cycle (monitor flags any spurious wb_valid).
    pass_op(OPCODE_ADD, 32'h00000005, 5'd3, 1'b1);
    @(posedge clk); #1;
    // Word load with ack 3 cycles after req: address aligned down to 0x1004.
    issue(OPCODE_LDW, 32'h00001006, 32'h0, 5'd4, 1'b1, 32'hDEADBEEF,
          1'b1, 1'b0, 32'h00001004, 32'h0, 4'hF, 3, 32'hDEADBEEF);
    // Byte loads on lane 3 (negative, sign-extended) and lane 0.
    issue(OPCODE_LDB, 32'h00000103, 32'h0, 5'd5, 1'b1, 32'hFFFFFF80,
          1'b1, 1'b0, 32'h00000103, 32'h0, 4'b1000, 1, 32'h80112233);
    issue(OPCODE_LDB, 32'h00000100, 32'h0, 5'd6, 1'b1, 32'h00000033,
          1'b1, 1'b0, 32'h00000100, 32'h0, 4'b0001, 0, 32'h80112233);
    // Stores retire without a register write; wb_data carries the ALU result.
    issue(OPCODE_STB, 32'h00000201, 32'h000000AB, 5'd7, 1'b0, 32'h00000201,
          1'b1, 1'b1, 32'h00000201, 32'hABABABAB, 4'b0010, 2, 32'h0);
    issue(OPCODE_STW, 32'h00000300, 32'h12345678, 5'd8, 1'b0, 32'h00000300,
          1'b1, 1'b1, 32'h00000300, 32'h12345678, 4'hF, 0, 32'h0);
    // Back-to-back: LDW with same-cycle ack, ADD held under stall, then STW.
    issue(OPCODE_LDW, 32'h00000404, 32'h0, 5'd9, 1'b1, 32'hCAFEF00D,
          1'b1, 1'b0, 32'h00000404, 32'h0, 4'hF, 0, 32'hCAFEF00D);
    pass_op(OPCODE_ADD, 32'h00000077, 5'd10, 1'b1);
    issue(OPCODE_STW, 32'h00000408, 32'h55AA55AA, 5'd11, 1'b0, 32'h00000408,
          1'b1, 1'b1, 32'h00000408, 32'h55AA55AA, 4'hF, 1, 32'h0);
    pass_op(OPCODE_SUB, 32'hFFFFFFFE, 5'd2, 1'b1);
    pass_op(OPCODE_BEQ, 32'h00000040, 5'd12, 1'b0);
    pass_op(7'h7F, 32'h00000123, 5'd13, 1'b0);
    @(posedge clk); #1;

    // Reset while waiting for ack: the access is abandoned and never retires.
    issue(OPCODE_LDW, 32'h00000500, 32'h0, 5'd14, 1'b1, 32'h0,
          1'b1, 1'b0, 32'h00000500, 32'h0, 4'hF, 50, 32'h11111111);
    @(posedge clk); #1;
    chk("wait_req_before_rst", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_wait_stall", {31'b0, ex_stall}, 32'd0);
    chk("rst_wait_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wait_mem_be", {28'b0, mem_be}, 32'd0);
    if (mq.size() > 0) void'(mq.pop_back());
    if (wbq.size() > 0) void'(wbq.pop_back());
    rst = 1'b0;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_ack_mem_req", {31'b0, mem_req}, 32'd0);
    chk("stray_ack_stall", {31'b0, ex_stall}, 32'd0);
    pass_op(OPCODE_ADD, 32'h00000009, 5'd1, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("wb_queue_drained", wbq.size(), 32'd0);
    chk("mem_queue_drained", mq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
